escalonador_sensores: RTL and testbench

Sequencer for the three-sensor ultrasonic front end. It fires the three HC-SR04 interfaces strictly one at a time, so one sensor's echo never corrupts another's reading. Each sensor gets a per-sensor timeout and a guard interval before the next one fires. The block sits between the top-level control FSM and the three sensor interfaces, and presents one coherent, registered set of three distances plus per-sensor error flags.

---
 rtl/escalonador_sensores_pkg.sv | 24 ++
 rtl/escalonador_sensores_contador.sv | 27 ++
 rtl/escalonador_sensores.sv | 175 +++++++++++++++++
 tb/tb_escalonador_sensores.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_sensores_pkg.sv
// Shared encodings and constants for the three-sensor ultrasonic sequencer.
package escalonador_sensores_pkg;

  localparam int unsigned N_SENSORES = 3;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned ESTADO_W   = 4;
  localparam int unsigned PREENCHE_W = 64;

  // Distance reported for a sensor that timed out; truncated to WIDTH at use.
  localparam logic [PREENCHE_W-1:0] VALOR_TIMEOUT = '1;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE    = 4'd0,
    DISPARA = 4'd1,
    ESPERA  = 4'd2,
    GUARDA  = 4'd3,
    FIM     = 4'd4
  } estado_t;

  function automatic logic [N_SENSORES-1:0] um_quente(input logic [IDX_W-1:0] idx);
    um_quente = N_SENSORES'(1) << idx;
  endfunction

endpackage

// File: rtl/escalonador_sensores_contador.sv
// Interval counter shared by the echo-timeout and guard phases.
module contador_intervalo #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         atingiu_c_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign atingiu_c_o = (cnt_q == lim_i);

endmodule

// File: rtl/escalonador_sensores.sv
// Fires three ultrasonic sensors one at a time and publishes a coherent,
// registered set of distances and timeout flags at the end of each sweep.
module escalonador_sensores
  import escalonador_sensores_pkg::*;
#(
  parameter int unsigned WIDTH          = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned GUARD_CYCLES   = 3_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  continuo,
  input  logic [N_SENSORES-1:0] pronto,
  input  logic [WIDTH-1:0]      medida0,
  input  logic [WIDTH-1:0]      medida1,
  input  logic [WIDTH-1:0]      medida2,
  output logic [N_SENSORES-1:0] medir,
  output logic [WIDTH-1:0]      dist0,
  output logic [WIDTH-1:0]      dist1,
  output logic [WIDTH-1:0]      dist2,
  output logic [N_SENSORES-1:0] erro,
  output logic                  fim,
  output logic                  ocupado,
  output logic [ESTADO_W-1:0]   db_estado
);

  localparam int unsigned MAX_CICLOS = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES
                                                                        : GUARD_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CICLOS);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_SENSORES - 1);

  estado_t                estado_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_SENSORES-1:0]  pronto_q;
  logic [WIDTH-1:0]       sombra_q [N_SENSORES];
  logic [N_SENSORES-1:0]  sombra_err_q;
  logic [WIDTH-1:0]       dist_q [N_SENSORES];
  logic [N_SENSORES-1:0]  erro_q;
  logic [N_SENSORES-1:0]  medir_q;
  logic                   fim_q;
  logic                   ocupado_q;

  logic [WIDTH-1:0]       medida_c [N_SENSORES];
  logic [N_SENSORES-1:0]  borda_c;
  logic                   borda_ativa_c;
  logic                   cnt_clr_c;
  logic                   cnt_en_c;
  logic [CW-1:0]          cnt_lim_c;
  logic                   cnt_fim_c;

  always_comb begin
    medida_c[0] = medida0;
    medida_c[1] = medida1;
    medida_c[2] = medida2;
  end

  // Only a fresh rising edge of the active sensor counts as an answer.
  assign borda_c       = pronto & ~pronto_q;
  assign borda_ativa_c = borda_c[idx_q];

  assign cnt_lim_c = (estado_q == ESPERA) ? CW'(TIMEOUT_CYCLES - 1) : CW'(GUARD_CYCLES - 1);

  // Counter is cleared on every phase boundary so it never runs past its limit.
  always_comb begin
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    case (estado_q)
      DISPARA: cnt_clr_c = 1'b1;
      ESPERA: begin
        cnt_en_c  = 1'b1;
        cnt_clr_c = borda_ativa_c | cnt_fim_c;
      end
      GUARDA: begin
        cnt_en_c  = 1'b1;
        cnt_clr_c = cnt_fim_c;
      end
      default: ;
    endcase
  end

  contador_intervalo #(
    .W (CW)
  ) u_contador (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (cnt_clr_c),
    .en_i        (cnt_en_c),
    .lim_i       (cnt_lim_c),
    .atingiu_c_o (cnt_fim_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= IDLE;
      idx_q        <= '0;
      pronto_q     <= '0;
      sombra_err_q <= '0;
      erro_q       <= '0;
      medir_q      <= '0;
      fim_q        <= 1'b0;
      ocupado_q    <= 1'b0;
      for (int i = 0; i < N_SENSORES; i++) begin
        sombra_q[i] <= '0;
        dist_q[i]   <= '0;
      end
    end else begin
      pronto_q <= pronto;
      medir_q  <= '0;
      fim_q    <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (iniciar || continuo) begin
            estado_q  <= DISPARA;
            idx_q     <= '0;
            medir_q   <= um_quente('0);
            ocupado_q <= 1'b1;
          end
        end
        DISPARA: estado_q <= ESPERA;
        ESPERA: begin
          if (borda_ativa_c) begin
            sombra_q[idx_q]     <= medida_c[idx_q];
            sombra_err_q[idx_q] <= 1'b0;
            estado_q            <= GUARDA;
          end else if (cnt_fim_c) begin
            sombra_q[idx_q]     <= WIDTH'(VALOR_TIMEOUT);
            sombra_err_q[idx_q] <= 1'b1;
            estado_q            <= GUARDA;
          end
        end
        GUARDA: begin
          if (cnt_fim_c) begin
            if (idx_q == ULTIMO) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
              erro_q   <= sombra_err_q;
              for (int i = 0; i < N_SENSORES; i++) begin
                dist_q[i] <= sombra_q[i];
              end
            end else begin
              estado_q <= DISPARA;
              idx_q    <= idx_q + IDX_W'(1);
              medir_q  <= um_quente(idx_q + IDX_W'(1));
            end
          end
        end
        FIM: begin
          if (continuo) begin
            estado_q <= DISPARA;
            idx_q    <= '0;
            medir_q  <= um_quente('0);
          end else begin
            estado_q  <= IDLE;
            ocupado_q <= 1'b0;
          end
        end
        default: begin
          estado_q  <= IDLE;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign medir     = medir_q;
  assign dist0     = dist_q[0];
  assign dist1     = dist_q[1];
  assign dist2     = dist_q[2];
  assign erro      = erro_q;
  assign fim       = fim_q;
  assign ocupado   = ocupado_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_escalonador_sensores.sv
// Bench for escalonador_sensores: sensor responder, medir/fim scoreboards,
// table of sweeps plus continuous-mode and mid-sweep reset sequences.
`timescale 1ns/1ps
module tb_escalonador_sensores;

  localparam int unsigned W  = 12;
  localparam int unsigned TO = 20;
  localparam int unsigned GU = 5;

  logic         clk;
  logic         reset;
  logic         iniciar;
  logic         continuo;
  logic [2:0]   pronto;
  logic [W-1:0] medida0, medida1, medida2;
  logic [2:0]   medir;
  logic [W-1:0] dist0, dist1, dist2;
  logic [2:0]   erro;
  logic         fim;
  logic         ocupado;
  logic [3:0]   db_estado;

  escalonador_sensores #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO),
    .GUARD_CYCLES   (GU)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .iniciar   (iniciar),
    .continuo  (continuo),
    .pronto    (pronto),
    .medida0   (medida0),
    .medida1   (medida1),
    .medida2   (medida2),
    .medir     (medir),
    .dist0     (dist0),
    .dist1     (dist1),
    .dist2     (dist2),
    .erro      (erro),
    .fim       (fim),
    .ocupado   (ocupado),
    .db_estado (db_estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           d0, d1, d2;
    logic [W-1:0] m0, m1, m2;
    bit           stale, foreign;
    logic [W-1:0] e0, e1, e2;
    logic [2:0]   err;
    int           fim_rel;
  } vec_t;

  typedef struct {
    int         c;
    logic [2:0] m;
  } ev_t;

  typedef struct {
    int           c;
    logic [W-1:0] d0, d1, d2;
    logic [2:0]   err;
  } res_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dly [3];
  int fire_at [3];
  int m0_cyc;
  bit stale0, foreign2;
  logic [3*W+2:0] prev_out;
  ev_t  medir_sb [$];
  res_t res_sb [$];
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c,
                              input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [W-1:0] mc,
                              input bit st, input bit fo,
                              input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [W-1:0] ec,
                              input logic [2:0] er, input int fr);
    vec_t v;
    v.d0 = a;  v.d1 = b;  v.d2 = c;
    v.m0 = ma; v.m1 = mb; v.m2 = mc;
    v.stale = st; v.foreign = fo;
    v.e0 = ea; v.e1 = eb; v.e2 = ec;
    v.err = er; v.fim_rel = fr;
    return v;
  endfunction

  // One clock: sensor responder, then both scoreboards.
  task automatic tick();
    ev_t ev;
    res_t r;
    logic [3*W+2:0] cur;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) if (fire_at[i] == cyc) pronto[i] = 1'b1;
    if (foreign2) begin
      if (cyc == m0_cyc + 1) pronto[2] = 1'b0;
      if (cyc == m0_cyc + 3) pronto[2] = 1'b1;
      if (cyc == m0_cyc + 4) pronto[2] = 1'b0;
    end
    if (medir != 3'b000) begin
      if (medir_sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL medir_inesperado: got %b expected no pulse (cycle %0d)", medir, cyc);
      end else begin
        ev = medir_sb.pop_front();
        chk("medir_ciclo", 32'(cyc), 32'(ev.c));
        chk("medir_valor", 32'(medir), 32'(ev.m));
        chk("estado_dispara", 32'(db_estado), 32'd1);
        chk("ocupado_dispara", 32'(ocupado), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
        if (medir[i]) begin
          if (i == 0) m0_cyc = cyc;
          if (!(stale0 && i == 0)) begin
            pronto[i]  = 1'b0;
            fire_at[i] = (dly[i] > 0) ? cyc + dly[i] : -1;
          end
        end
      end
    end
    cur = {dist0, dist1, dist2, erro};
    if (fim) begin
      if (res_sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL fim_inesperado: got fim=1 expected 0 (cycle %0d)", cyc);
      end else begin
        r = res_sb.pop_front();
        chk("fim_ciclo", 32'(cyc), 32'(r.c));
        chk("dist0", 32'(dist0), 32'(r.d0));
        chk("dist1", 32'(dist1), 32'(r.d1));
        chk("dist2", 32'(dist2), 32'(r.d2));
        chk("erro", 32'(erro), 32'(r.err));
        chk("estado_fim", 32'(db_estado), 32'd4);
      end
    end else if (cur != prev_out) begin
      checks++; failures++;
      $display("FAIL saida_parcial: got %h expected %h (outputs changed without fim, cycle %0d)",
               cur, prev_out, cyc);
    end
    prev_out = cur;
  endtask

  // Expected medir schedule from slot lengths; expected result from the table.
  task automatic plan(input int t, input vec_t v);
    ev_t  ev;
    res_t r;
    int   s, k;
    s = t + 1;
    for (int i = 0; i < 3; i++) begin
      ev.c = s;
      ev.m = 3'(1 << i);
      medir_sb.push_back(ev);
      k = (dly[i] == 0 || dly[i] > int'(TO)) ? int'(TO) : dly[i];
      if (i == 0 && v.stale) k = int'(TO);
      s = s + 1 + k + int'(GU);
    end
    r.c = t + v.fim_rel;
    r.d0 = v.e0; r.d1 = v.e1; r.d2 = v.e2;
    r.err = v.err;
    res_sb.push_back(r);
  endtask

  task automatic setup(input vec_t v);
    dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2;
    medida0 = v.m0; medida1 = v.m1; medida2 = v.m2;
    stale0 = v.stale; foreign2 = v.foreign;
  endtask

  task automatic drain(input int budget, input string name);
    int g;
    g = 0;
    while ((res_sb.size() > 0 || medir_sb.size() > 0) && g < budget) begin
      tick();
      g++;
    end
    if (res_sb.size() > 0 || medir_sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, res_sb.size() + medir_sb.size());
      res_sb.delete();
      medir_sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    setup(v);
    if (v.stale) begin
      pronto[0] = 1'b1;
      tick();
      tick();
    end
    iniciar = 1'b1;
    t = cyc;
    plan(t, v);
    tick();
    iniciar = 1'b0;
    drain(300, "sweep");
    tick();
    chk("ocupado_idle", 32'(ocupado), 32'd0);
    chk("estado_idle", 32'(db_estado), 32'd0);
    stale0 = 1'b0;
    foreign2 = 1'b0;
  endtask

  initial begin
    int t, g;
    reset = 1'b0; iniciar = 1'b0; continuo = 1'b0; pronto = '0;
    medida0 = '0; medida1 = '0; medida2 = '0;
    for (int i = 0; i < 3; i++) begin dly[i] = 0; fire_at[i] = -1; end
    m0_cyc = -100; stale0 = 1'b0; foreign2 = 1'b0; prev_out = '0;

    vecs[0] = mk(8, 8, 8,   12'd100, 12'd200, 12'd300, 1'b0, 1'b0, 12'd100, 12'd200, 12'd300, 3'b000, 43);
    vecs[1] = mk(8, 0, 8,   12'd111, 12'd222, 12'd333, 1'b0, 1'b0, 12'd111, 12'hFFF, 12'd333, 3'b010, 55);
    vecs[2] = mk(20, 3, 1,  12'd55,  12'd66,  12'd77,  1'b0, 1'b0, 12'd55,  12'd66,  12'd77,  3'b000, 43);
    vecs[3] = mk(0, 5, 19,  12'd9,   12'd10,  12'd11,  1'b1, 1'b1, 12'hFFF, 12'd10,  12'd11,  3'b001, 63);
    vecs[4] = mk(1, 1, 1,   12'd1,   12'd2,   12'hFFF, 1'b0, 1'b0, 12'd1,   12'd2,   12'hFFF, 3'b000, 22);
    vecs[5] = mk(0, 0, 0,   12'd5,   12'd6,   12'd7,   1'b0, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 3'b111, 79);
    vecs[6] = mk(21, 2, 2,  12'd5,   12'd6,   12'd7,   1'b0, 1'b0, 12'hFFF, 12'd6,   12'd7,   3'b001, 43);

    tick();
    tick();
    chk("rst_medir", 32'(medir), 32'd0);
    chk("rst_fim", 32'(fim), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_dist0", 32'(dist0), 32'd0);
    chk("rst_dist1", 32'(dist1), 32'd0);
    chk("rst_dist2", 32'(dist2), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    reset = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Continuous mode: back-to-back sweeps, mid-sweep iniciar must be ignored.
    setup(vecs[0]);
    continuo = 1'b1;
    t = cyc;
    plan(t, vecs[0]);
    plan(t + 43, vecs[0]);
    g = 0;
    while ((res_sb.size() > 0 || medir_sb.size() > 0) && g < 300) begin
      tick();
      g++;
      iniciar = (cyc == t + 20);
      if (cyc == t + 50) continuo = 1'b0;
    end
    iniciar = 1'b0;
    continuo = 1'b0;
    drain(1, "continuo");
    repeat (40) tick();
    chk("continuo_parou", 32'(ocupado), 32'd0);

    // Reset during the guard interval of sensor 1 aborts the sweep.
    setup(vecs[0]);
    iniciar = 1'b1;
    t = cyc;
    plan(t, vecs[0]);
    tick();
    iniciar = 1'b0;
    g = 0;
    while (cyc < t + 25 && g < 100) begin
      tick();
      g++;
    end
    chk("pre_rst_estado", 32'(db_estado), 32'd3);
    chk("pre_rst_dist0", 32'(dist0), 32'd100);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_medir", 32'(medir), 32'd0);
    chk("arst_fim", 32'(fim), 32'd0);
    chk("arst_ocupado", 32'(ocupado), 32'd0);
    chk("arst_estado", 32'(db_estado), 32'd0);
    chk("arst_dist0", 32'(dist0), 32'd0);
    chk("arst_dist1", 32'(dist1), 32'd0);
    chk("arst_dist2", 32'(dist2), 32'd0);
    chk("arst_erro", 32'(erro), 32'd0);
    medir_sb.delete();
    res_sb.delete();
    prev_out = '0;
    tick();
    tick();
    reset = 1'b1;
    repeat (60) tick();
    chk("pos_rst_ocupado", 32'(ocupado), 32'd0);
    chk("pos_rst_dist1", 32'(dist1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1 ms");
    $fatal(1);
  end

endmodule
